i2c_target_fsm: RTL and testbench
=================================

Name: i2c_target_fsm

Overview:
- Single-address I2C target (slave) FSM; the responder counterpart to the team's single-master I2C controller.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, and then receives write bytes or transmits read bytes.
- Exchanges bytes with user logic through a valid/request interface.
- Open-drain output only: the block pulls SDA low and never drives it high.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target responds to.

Ports:
- clk  in  1  system clock; at least 8x SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  raw SCL pin level, asynchronous.
- sda_i  in  1  raw SDA pin level, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- rx_data  out  8  last byte received in a write transfer.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- tx_data  in  8  next byte to transmit; sampled when tx_req pulses.
- tx_req  out  1  one-cycle pulse; tx_data is loaded this cycle, and user logic may advance.
- addressed  out  1  high from address-ACK until STOP, repeated START, or NACKed read.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). All flops reset on rst_n low.
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, addressed=0, state=IDLE.
- Input synchronisation: scl_i and sda_i pass through 2-flop synchronizers.
- Edge detection: scl_rise/scl_fall and sda edges come from the synchronized value vs its 1-cycle delayed copy.
  - START: sda falling while SCL high.
  - STOP: sda rising while SCL high.
- Timing rules:
  - Data is sampled on scl_rise.
  - sda_oe changes only on scl_fall.
- START from any state, including mid-byte (repeated START): go to ADDR, clear bit counter, sda_oe=0, addressed=0.
- STOP from any state: go to IDLE, sda_oe=0, addressed=0.
- START and STOP have priority over all data events in the same cycle.
- Bit counter: 3 bits; counts sampled bits; wraps 7->0 on the 8th bit.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. After the 8th rise:
    - addr[7:1]==TARGET_ADDR -> ADDR_ACK.
    - Otherwise -> IDLE; sda_oe stays 0 for the rest of the transfer.
  - ADDR_ACK: on the first scl_fall, sda_oe=1 and addressed=1. On the next scl_fall, sda_oe=0, then:
    - rw=0 -> WRITE.
    - rw=1 -> READ; tx_req pulses and tx_data loads into the shift register; sda_oe=~tx_data[7] in the same cycle.
  - WRITE: shift 8 bits. On the 8th rise, rx_data updates and rx_valid pulses on the following cycle. Then WR_ACK.
  - WR_ACK: on scl_fall, sda_oe=1 (always ACK). On the next scl_fall, sda_oe=0 -> WRITE.
  - READ: on each scl_fall, sda_oe=~shift[7] for the next bit. After the 8th bit's scl_fall, sda_oe=0 -> RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - SDA=0 (ACK) -> READ; on the next scl_fall, tx_req pulses and the next byte loads.
    - SDA=1 (NACK) -> IDLE, addressed=0; wait for STOP/START.
- Response latency: sda_oe changes 3 clk cycles after the raw scl_i falling edge (2 sync + 1 register).
- tx_req and rx_valid never assert in the same cycle.
- User back-pressure: none. tx_data must be stable in the tx_req cycle.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: after the synchronizers, each line passes through a 3-sample shift register. The filtered level changes only when all 3 samples agree, which rejects pulses under 3 clk cycles. This adds 2 cycles of latency (sda_oe response = 5 cycles after raw SCL fall).
- Undefined: synchronizer output is used directly.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_tgt_state_t (IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK).
  - Constants I2C_RW_READ=1'b1, I2C_ACK=1'b0, I2C_NACK=1'b1.
- Sub-module i2c_line_sync: a synchronizer plus optional glitch filter plus edge detector. Instantiated once for SCL and once for SDA.

Test Plan:
- Write, TARGET_ADDR=7'h50: START, 0xA0, 0x3C, STOP -> sda_oe=1 during both ACK bits; rx_valid pulses once with rx_data=0x3C; addressed returns to 0 after STOP.
- Address mismatch: START, 0xA2, 0x55, STOP -> sda_oe never asserts; rx_valid never pulses.
- Read: START, 0xA1, tx_data=0x96 -> SDA bits 1,0,0,1,0,1,1,0. Master ACKs, tx_data=0x5A -> second byte 0x5A. Master NACKs -> state IDLE, sda_oe=0, tx_req pulsed exactly twice.
- Repeated START: START, 0xA0, 0x11, START, 0xA1, read 0x22 with NACK, STOP -> rx_data=0x11; first read byte on the bus is 0x22; no spurious ACK.
- Reset mid-transfer: assert rst_n low during bit 4 of a write data byte -> all outputs at reset values immediately. After release, the next START, 0xA0, 0x77 is received correctly.
- Glitch filter (with I2C_TARGET_GLITCH_FILTER_EN): a 2-cycle SDA low pulse while SCL is high -> no START detected. Without the macro, the same pulse is detected as START+STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// Optional glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WR_ACK,
    READ,
    RD_ACK
  } i2c_tgt_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer, optional glitch filter and edge detector.
// Glitch filter enabled by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  // Bus idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic h0;
  logic h1;
  logic held;
  logic agree;

  // Level moves only once three consecutive samples agree.
  assign agree = (s2 == h0) && (h0 == h1);
  assign level = agree ? s2 : held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0   <= 1'b1;
      h1   <= 1'b1;
      held <= 1'b1;
    end else begin
      h0   <= s2;
      h1   <= h0;
      held <= level;
    end
  end
`else
  assign level = s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/i2c_target_fsm.sv
// Single-address I2C target: START/STOP, address match, ACK, rx/tx bytes.
// Optional glitch filter on SCL/SDA: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_fsm
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed
);

  logic scl;
  logic scl_rise;
  logic scl_fall;
  logic sda;
  logic sda_rise;
  logic sda_fall;

  i2c_line_sync u_scl (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (scl_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync u_sda (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sda_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start;
  logic stop;

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  i2c_tgt_state_t state;
  logic [7:0]     shift;
  logic [7:0]     shift_in;
  logic [2:0]     bit_cnt;
  logic           last_bit;
  logic           phase;
  logic           rw;
  logic           rx_pend;

  assign shift_in = {shift[6:0], sda};
  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      phase     <= 1'b0;
      rw        <= 1'b0;
      rx_pend   <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addressed <= 1'b0;
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= rx_pend;
      rx_pend  <= 1'b0;
      if (start) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        phase     <= 1'b0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
      end else if (stop) begin
        state     <= IDLE;
        phase     <= 1'b0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            bit_cnt <= 3'd0;
          end
          ADDR: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                rw    <= sda;
                phase <= 1'b0;
                if (shift[6:0] == TARGET_ADDR) begin
                  state <= ADDR_ACK;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe    <= 1'b1;
                addressed <= 1'b1;
                phase     <= 1'b1;
              end else begin
                bit_cnt <= 3'd0;
                phase   <= 1'b0;
                if (rw == I2C_RW_READ) begin
                  state  <= READ;
                  tx_req <= 1'b1;
                  shift  <= tx_data;
                  sda_oe <= ~tx_data[7];
                end else begin
                  state  <= WRITE;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          WRITE: begin
            if (scl_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                rx_data <= shift_in;
                rx_pend <= 1'b1;
                phase   <= 1'b0;
                state   <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= WRITE;
              end
            end
          end
          READ: begin
            // Counter wraps to 0 after the 8th rise; that fall ends the byte.
            if (scl_rise) begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                phase  <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~shift[7];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_ACK) begin
                phase <= 1'b1;
              end else begin
                state     <= IDLE;
                addressed <= 1'b0;
              end
            end else if (scl_fall && phase) begin
              tx_req  <= 1'b1;
              shift   <= tx_data;
              sda_oe  <= ~tx_data[7];
              bit_cnt <= 3'd0;
              phase   <= 1'b0;
              state   <= READ;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_fsm.sv
// Directed bench for i2c_target_fsm acting as the bus master.
// Honours I2C_TARGET_GLITCH_FILTER_EN for latency and glitch checks.
module tb_i2c_target_fsm;
  import i2c_pkg::*;

  localparam int Q = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int LAT = 5;
  localparam logic GLITCH_SEEN = 1'b0;
`else
  localparam int LAT = 3;
  localparam logic GLITCH_SEEN = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  wire        sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       addressed;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_fsm #(.TARGET_ADDR(7'h50)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .addressed (addressed)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int oe_cyc = 0;
  int rxv_cyc = 0;
  int txr_cyc = 0;
  int both_cyc = 0;
  int addr_cyc = 0;

  always @(posedge clk) begin
    if (sda_oe) oe_cyc++;
    if (rx_valid) rxv_cyc++;
    if (tx_req) txr_cyc++;
    if (rx_valid && tx_req) both_cyc++;
    if (dut.state == ADDR) addr_cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic bit_io(input logic b, output logic r);
    sda_m = b;  tick(Q);
    scl = 1'b1; tick(Q);
    r = sda_line;
    tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ackl);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, ackl);
  endtask

  task automatic read_byte(input logic ack_b, input logic [7:0] nxt,
                           output logic [7:0] d, output logic ackl);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, r);
      d = {d[6:0], r};
    end
    tx_data = nxt;
    bit_io(ack_b, ackl);
  endtask

  logic       a;
  logic       r;
  logic [7:0] d;
  logic [7:0] byte_a;
  int         s0;
  int         s1;

  initial begin
    rst_n = 1'b0;
    scl = 1'b1;
    sda_m = 1'b1;
    tx_data = 8'h00;
    tick(3);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_tx_req", 32'(tx_req), 0);
    chk("rst_addressed", 32'(addressed), 0);
    rst_n = 1'b1;
    tick(Q);

    // Write 0x3C with exact ACK release latency on the address ACK.
    s0 = rxv_cyc;
    bus_start();
    d = 8'hA0;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    a = sda_line;
    tick(Q);
    scl = 1'b0;
    tick(LAT - 1);
    chk("lat_hold", 32'(sda_oe), 1);
    tick(1);
    chk("lat_release", 32'(sda_oe), 0);
    tick(Q - LAT);
    chk("wr_addr_ack", 32'(a), 0);
    write_byte(8'h3C, a);
    chk("wr_data_ack", 32'(a), 0);
    chk("wr_addressed", 32'(addressed), 1);
    chk("wr_rxv_once", 32'(rxv_cyc - s0), 1);
    chk("wr_rx_data", 32'(rx_data), 32'h3C);
    bus_stop();
    chk("wr_stop_addressed", 32'(addressed), 0);

    // Address mismatch.
    s0 = oe_cyc;
    s1 = rxv_cyc;
    bus_start();
    write_byte(8'hA2, a);
    chk("mm_addr_nack", 32'(a), 1);
    write_byte(8'h55, a);
    chk("mm_data_nack", 32'(a), 1);
    bus_stop();
    chk("mm_no_oe", 32'(oe_cyc - s0), 0);
    chk("mm_no_rxv", 32'(rxv_cyc - s1), 0);

    // Read 0x96 then 0x5A, NACK last.
    s0 = txr_cyc;
    tx_data = 8'h96;
    bus_start();
    write_byte(8'hA1, a);
    chk("rd_addr_ack", 32'(a), 0);
    read_byte(1'b0, 8'h5A, d, a);
    chk("rd_byte0", 32'(d), 32'h96);
    read_byte(1'b1, 8'hFF, d, a);
    chk("rd_byte1", 32'(d), 32'h5A);
    chk("rd_nack_line", 32'(a), 1);
    chk("rd_state_idle", 32'(dut.state), 32'(IDLE));
    chk("rd_sda_oe", 32'(sda_oe), 0);
    chk("rd_addressed", 32'(addressed), 0);
    chk("rd_txreq_twice", 32'(txr_cyc - s0), 2);
    bus_stop();

    // Repeated START from write into read.
    tx_data = 8'h22;
    bus_start();
    write_byte(8'hA0, a);
    chk("rs_wr_ack", 32'(a), 0);
    write_byte(8'h11, a);
    chk("rs_data_ack", 32'(a), 0);
    bus_start();
    write_byte(8'hA1, a);
    chk("rs_rd_ack", 32'(a), 0);
    read_byte(1'b1, 8'h00, byte_a, a);
    chk("rs_rd_byte", 32'(byte_a), 32'h22);
    chk("rs_nack_line", 32'(a), 1);
    bus_stop();
    chk("rs_rx_data", 32'(rx_data), 32'h11);

    // Reset during bit 4 of a write data byte.
    bus_start();
    write_byte(8'hA0, a);
    bit_io(1'b1, r);
    bit_io(1'b0, r);
    bit_io(1'b1, r);
    chk("rm_addressed_pre", 32'(addressed), 1);
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    rst_n = 1'b0;
    #1;
    chk("rm_sda_oe", 32'(sda_oe), 0);
    chk("rm_rx_data", 32'(rx_data), 0);
    chk("rm_rx_valid", 32'(rx_valid), 0);
    chk("rm_tx_req", 32'(tx_req), 0);
    chk("rm_addressed", 32'(addressed), 0);
    tick(4);
    rst_n = 1'b1;
    tick(2);
    sda_m = 1'b1;
    tick(Q);
    bus_start();
    write_byte(8'hA0, a);
    chk("rm_post_addr_ack", 32'(a), 0);
    write_byte(8'h77, a);
    chk("rm_post_data_ack", 32'(a), 0);
    bus_stop();
    chk("rm_post_rx_data", 32'(rx_data), 32'h77);

    // Two-cycle SDA low pulse while SCL high.
    tick(Q);
    s0 = addr_cyc;
    sda_m = 1'b0;
    tick(2);
    sda_m = 1'b1;
    tick(12);
    chk("glitch_start_seen", 32'(addr_cyc != s0), 32'(GLITCH_SEEN));
    chk("glitch_state_idle", 32'(dut.state), 32'(IDLE));

    chk("txreq_rxv_disjoint", 32'(both_cyc), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
